nes_tetris_soc_gpio_in_irq: RTL



---
 rtl/nes_tetris_soc_gpio_in_irq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nes_tetris_soc_gpio_in_irq.sv
// ============================================================================
// Module  : nes_tetris_soc_gpio_in_irq
// Brief   : Avalon-MM input port with synchroniser, edge capture and irq.
//           Optional macro GPIO_IN_DEBOUNCE_EN adds a per-bit debounce filter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_tetris_soc_gpio_in_irq #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 1,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [1:0]       arm_q;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_rise, w_fall, w_sel;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_armed;
  logic             w_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int c_CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
      logic [c_CNT_W-1:0] cnt_q;
      logic               filt_q;

      // The filtered bit flips on the edge the counter would reach DEBOUNCE_CYCLES.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (sync2_q[i] == filt_q) begin
          cnt_q  <= '0;
        end else if (cnt_q == c_CNT_LAST) begin
          cnt_q  <= '0;
          filt_q <= sync2_q[i];
        end else begin
          cnt_q  <= cnt_q + 1'b1;
        end
      end

      assign w_data[i] = filt_q;
    end
  endgenerate
`else
  assign w_data = sync2_q;
`endif

  assign w_rise  = w_data & ~prev_q;
  assign w_fall  = ~w_data & prev_q;
  assign w_armed = (arm_q == 2'd3);
  assign w_wr    = chipselect & ~write_n;
  assign w_clr   = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_sel = '0;
    if (w_armed) begin
      if (EDGE_TYPE == 0)      w_sel = w_rise;
      else if (EDGE_TYPE == 1) w_sel = w_fall;
      else                     w_sel = w_rise | w_fall;
    end
  end

  // A new edge takes priority over a simultaneous write-1-to-clear.
  assign edge_capture_d = w_sel | (edge_capture_q & ~w_clr);
  assign irqmask_d      = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = w_data;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q         <= '0;
      irqmask_q      <= '0;
      edge_capture_q <= '0;
      arm_q          <= 2'd0;
      readdata_q     <= '0;
    end else begin
      prev_q         <= w_data;
      irqmask_q      <= irqmask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      if (!w_armed) arm_q <= arm_q + 2'd1;
    end
  end

  assign readdata = readdata_q;
  assign irq      = (IRQ_TYPE == 1) ? |(edge_capture_q & irqmask_q)
                                    : |(w_data & irqmask_q);

  assign w_unused = ^writedata;

endmodule

`default_nettype wire
